// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_types;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_resp_latch.sv
// Per-cache done-flag latch: remembers an early response until the whole
// memory stall releases, so the request is not re-issued and data is replayed.
module resp_latch (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  input  logic stall,
  output logic ok,
  output logic masked_req,
  output logic hold_load,
  output logic hold_sel
);

  logic done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else if (!stall) begin
      done_q <= 1'b0;
    end else if (hold_load) begin
      done_q <= 1'b1;
    end
  end

  assign ok         = ~req | done_q | resp;
  assign masked_req = ~rst & req & ~done_q;
  assign hold_load  = ~rst & resp & stall;
  assign hold_sel   = ~rst & done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: merges cache stalls, load-use bubbles and branch
// redirects into per-stage load/flush enables, with saturating perf counters.
module hazard_ctrl
  import hazard_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_stall,
  input  logic             br_redirect,
  input  logic             icache_req,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  output logic             icache_read_out,
  output logic             dcache_en_out,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             bubble_exmem,
  output logic             ic_hold_load,
  output logic             ic_hold_sel,
  output logic             dc_hold_load,
  output logic             dc_hold_sel,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hazard_state_t state, state_next;
  logic ic_ok, dc_ok, mem_stall;
  logic load_use_applied, flush_applied;

  resp_latch u_ic_latch (
    .clk        (clk),
    .rst        (rst),
    .req        (icache_req),
    .resp       (icache_resp),
    .stall      (mem_stall),
    .ok         (ic_ok),
    .masked_req (icache_read_out),
    .hold_load  (ic_hold_load),
    .hold_sel   (ic_hold_sel)
  );

  resp_latch u_dc_latch (
    .clk        (clk),
    .rst        (rst),
    .req        (dcache_req),
    .resp       (dcache_resp),
    .stall      (mem_stall),
    .ok         (dc_ok),
    .masked_req (dcache_en_out),
    .hold_load  (dc_hold_load),
    .hold_sel   (dc_hold_sel)
  );

  assign mem_stall = ~(ic_ok & dc_ok);

  // Redirect is ignored under a load-use bubble: the branch operands are not valid yet.
  assign load_use_applied = ~rst & ~mem_stall & forward_stall;
  assign flush_applied    = ~rst & ~mem_stall & ~forward_stall & br_redirect;

  always_comb begin
    load_pc      = 1'b1;
    load_ifid    = 1'b1;
    load_idex    = 1'b1;
    load_exmem   = 1'b1;
    load_memwb   = 1'b1;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    bubble_exmem = 1'b0;
    if (rst) begin
      {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = 5'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (mem_stall) begin
      {load_pc, load_ifid, load_idex, load_exmem, load_memwb} = 5'b0;
    end else if (forward_stall) begin
      load_pc      = 1'b0;
      load_ifid    = 1'b0;
      load_idex    = 1'b0;
      bubble_exmem = 1'b1;
    end else if (br_redirect) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mem_stall) state_next = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // All three counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      load_use_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (mem_stall && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + CNT_ONE;
      if (load_use_applied && load_use_cnt != CNT_MAX) load_use_cnt <= load_use_cnt + CNT_ONE;
      if (flush_applied && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl with a scoreboard queue fed by
// a behavioural model and drained by an independent monitor.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [13:0]      ctrl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] lu;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic forward_stall = 1'b0, br_redirect = 1'b0;
  logic icache_req = 1'b0, icache_resp = 1'b0, dcache_req = 1'b0, dcache_resp = 1'b0;
  logic icache_read_out, dcache_en_out;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex, bubble_exmem;
  logic ic_hold_load, ic_hold_sel, dc_hold_load, dc_hold_sel;
  logic [CNT_W-1:0] stall_cycles, load_use_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_stall(forward_stall), .br_redirect(br_redirect),
    .icache_req(icache_req), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .icache_read_out(icache_read_out), .dcache_en_out(dcache_en_out),
    .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
    .load_exmem(load_exmem), .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .bubble_exmem(bubble_exmem),
    .ic_hold_load(ic_hold_load), .ic_hold_sel(ic_hold_sel),
    .dc_hold_load(dc_hold_load), .dc_hold_sel(dc_hold_sel),
    .stall_cycles(stall_cycles), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  bit stim_done = 1'b0;

  // Reference model state: which cache has already answered, and plain integer counters.
  bit m_ic_served = 1'b0, m_dc_served = 1'b0;
  int m_stalls = 0, m_load_use = 0, m_flushes = 0;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic applyStimulus(input bit r, input bit fs, input bit br,
                               input bit icr, input bit icp, input bit dcr, input bit dcp);
    exp_t e;
    bit ic_ready, dc_ready, waiting;
    bit lpc, lif, lid, lex, lmw, fif, fid, bub;
    @(posedge clk);
    #1;
    rst = r; forward_stall = fs; br_redirect = br;
    icache_req = icr; icache_resp = icp; dcache_req = dcr; dcache_resp = dcp;

    ic_ready = !icr || m_ic_served || icp;
    dc_ready = !dcr || m_dc_served || dcp;
    waiting  = !(ic_ready && dc_ready);

    {lpc, lif, lid, lex, lmw, fif, fid, bub} = 8'b11111_000;
    if (r) begin
      {lpc, lif, lid, lex, lmw, fif, fid, bub} = 8'b00000_110;
    end else if (waiting) begin
      {lpc, lif, lid, lex, lmw} = 5'b0;
    end else if (fs) begin
      {lpc, lif, lid, bub} = 4'b0001;
    end else if (br) begin
      {fif, fid} = 2'b11;
    end

    e.ctrl = {!r && icr && !m_ic_served, !r && dcr && !m_dc_served,
              lpc, lif, lid, lex, lmw, fif, fid, bub,
              !r && icp && waiting, !r && m_ic_served,
              !r && dcp && waiting, !r && m_dc_served};
    e.sc = CNT_W'(m_stalls);
    e.lu = CNT_W'(m_load_use);
    e.fc = CNT_W'(m_flushes);
    exp_q.push_back(e);

    if (r) begin
      m_ic_served = 1'b0; m_dc_served = 1'b0;
      m_stalls = 0; m_load_use = 0; m_flushes = 0;
    end else if (waiting) begin
      m_stalls = sat_inc(m_stalls);
      m_ic_served = m_ic_served || icp;
      m_dc_served = m_dc_served || dcp;
    end else begin
      m_ic_served = 1'b0; m_dc_served = 1'b0;
      if (fs) m_load_use = sat_inc(m_load_use);
      else if (br) m_flushes = sat_inc(m_flushes);
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("ctrl", int'({icache_read_out, dcache_en_out, load_pc, load_ifid, load_idex,
                                  load_exmem, load_memwb, flush_ifid, flush_idex, bubble_exmem,
                                  ic_hold_load, ic_hold_sel, dc_hold_load, dc_hold_sel}), int'(e.ctrl));
        checkOutput("stall_cycles", int'(stall_cycles), int'(e.sc));
        checkOutput("load_use_cnt", int'(load_use_cnt), int'(e.lu));
        checkOutput("flush_cnt", int'(flush_cnt), int'(e.fc));
      end
    end
  end

  initial begin
    // reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    // plain run
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1, 0, 0);
    // split miss: icache answers at cycle 2, dcache at cycle 5
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    // load-use, then load-use masking a redirect, then the redirect alone
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    // redirect held across a dcache miss
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    // reset while the icache response is latched
    applyStimulus(0, 0, 0, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, 1);
    // long stall saturates the stall counter
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    @(posedge clk);
    stim_done = 1'b1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
